// File: rtl/instr_sequencer.sv
// instr_sequencer: one-hot phase sequencer with an optional execute/writeback replay.
// Single-step build option: define INSTR_SEQUENCER_SINGLE_STEP_EN (adds step input, WAIT_STEP).
module instr_sequencer #(
    parameter int STEP_PHASES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             num_of_ope,
    input  logic                   stall,
    input  logic                   halt,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic [STEP_PHASES-1:0] phase,
    output logic                   cycle_sel,
    output logic                   instr_done,
    output logic [15:0]            instr_count,
    output logic                   busy
);

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        HOLD      = 3'd2,
        HALT      = 3'd3,
        WAIT_STEP = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_e;
`endif

    localparam logic [STEP_PHASES-1:0] PH_FETCH = STEP_PHASES'(1);
    localparam logic [STEP_PHASES-1:0] PH_EXEC  = STEP_PHASES'(16);

    state_e                 state_q;
    logic [STEP_PHASES-1:0] phase_q;
    logic [STEP_PHASES-1:0] phase_rot_d;
    logic                   sel_q;
    logic                   done_q;
    logic                   busy_q;
    logic [15:0]            count_q;
    logic [1:0]             ops_q;
    logic [1:0]             ops_d;
    logic                   hold_d;
    logic                   replay_d;

    assign phase_rot_d = {phase_q[STEP_PHASES-2:0], phase_q[STEP_PHASES-1]};
    // Zero ops still needs one pass; anything above two shares the two-pass path.
    assign ops_d       = (|num_of_ope[3:1]) ? 2'd2 : 2'd1;
    assign hold_d      = stall && (phase_q[0] || phase_q[5]);
    assign replay_d    = !sel_q && (ops_q == 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= 16'h0000;
            ops_q   <= 2'd1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    state_q <= RUN;
                    phase_q <= PH_FETCH;
                    sel_q   <= 1'b0;
                    busy_q  <= 1'b1;
                end
                RUN: begin
                    if (hold_d) begin
                        state_q <= HOLD;
                    end else if (phase_q[STEP_PHASES-1]) begin
                        if (replay_d) begin
                            phase_q <= PH_EXEC;
                            sel_q   <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                            count_q <= count_q + 16'd1;
                            sel_q   <= 1'b0;
                            if (halt) begin
                                state_q <= HALT;
                                phase_q <= '0;
                                busy_q  <= 1'b0;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
                            end else begin
                                state_q <= WAIT_STEP;
                                phase_q <= '0;
                                busy_q  <= 1'b0;
                            end
`else
                            end else begin
                                phase_q <= PH_FETCH;
                            end
`endif
                        end
                    end else begin
                        if (phase_q[1]) begin
                            ops_q <= ops_d;
                        end
                        phase_q <= phase_rot_d;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_q <= RUN;
                        phase_q <= phase_rot_d;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
                WAIT_STEP: begin
                    if (step) begin
                        state_q <= RUN;
                        phase_q <= PH_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    phase_q <= '0;
                    sel_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign phase       = phase_q;
    assign cycle_sel   = sel_q;
    assign instr_done  = done_q;
    assign instr_count = count_q;
    assign busy        = busy_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The module SHALL have the following ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- num_of_ope  input  4  micro-cycle count from decode; sampled at end of phase 2.
- stall  input  1  memory/fetch busy; holds sequencing while high.
- halt  input  1  stop request; honoured only at an instruction boundary.
- phase  output  8  one-hot phase strobes; bit0 is fetch, bit1 is decode, bit4 is execute/register load.
- cycle_sel  output  1  0 for the first micro-cycle, 1 for the second; drives the ALU result selector.
- instr_done  output  1  one-cycle pulse on the final phase 8 of an instruction.
- instr_count  output  16  retired instruction count.
- busy  output  1  high while in RUN or HOLD.

REQ-002 The module SHALL have the following parameter: STEP_PHASES, default 8, the number of phases per micro-cycle; the only legal value is 8.

Function
REQ-003 The FSM SHALL have the states IDLE, RUN, HOLD and HALT, encoded in 2 bits.
REQ-004 IDLE SHALL go to RUN on the first rising edge after reset release, asserting phase=8'h01 with cycle_sel=0.
REQ-005 In RUN, phase SHALL rotate left by one bit per clock, giving exactly one cycle per phase.
REQ-006 At the end of phase bit1, num_of_ope SHALL be latched into an internal register with these rules: 0 is treated as 1, and any value of 2 or more is clamped to 2.
REQ-007 On phase bit7 with cycle_sel=0 and latched count=2, the next phase SHALL be 8'h10, with cycle_sel=1 (replay of execute/writeback only).
REQ-008 On phase bit7 of the final micro-cycle, the module SHALL:
- pulse instr_done for one cycle;
- increment instr_count modulo 2^16 (16'hFFFF wraps to 16'h0000);
- set the next phase to 8'h01 with cycle_sel=0.
REQ-009 RUN SHALL go to HOLD when stall=1 while phase is bit0 or bit5; in HOLD, phase and cycle_sel SHALL be frozen at their current value.
REQ-010 HOLD SHALL return to RUN on the first clock with stall=0, advancing one phase on that edge.
REQ-011 stall SHALL have no effect on any other phase.
REQ-012 halt SHALL be sampled only on the final phase bit7.
- If halt=1, the next state SHALL be HALT, with phase=8'h00, busy=0 and cycle_sel=0.
- instr_done and the count increment SHALL still occur on that edge.
- HALT SHALL be exited only by reset.
REQ-013 When halt and stall are both high on a stall-eligible phase, stall SHALL win; halt is re-evaluated at the next boundary.
REQ-014 The phase output SHALL always be one-hot in RUN/HOLD and all-zero in IDLE/HALT.

Reset
REQ-015 While reset=0, all outputs and state SHALL take these values asynchronously:
- state=IDLE, phase=8'h00, cycle_sel=0;
- instr_done=0, instr_count=16'h0000, busy=0;
- latched count=1.
REQ-016 Reset asserted mid-instruction, including in HOLD or a second micro-cycle, SHALL abort immediately with no instr_done pulse and no count change.

Configuration
REQ-017 The preprocessor macro INSTR_SEQUENCER_SINGLE_STEP_EN SHALL control single-stepping as follows:
- When defined, it adds input step (1 bit) and state WAIT_STEP.
- In that build, the final phase bit7 SHALL enter WAIT_STEP (phase=8'h00, busy=0) instead of restarting.
- The sequencer SHALL leave WAIT_STEP to phase 8'h01 on the first clock with step=1.
- halt takes priority over WAIT_STEP.
- When undefined, the step port and WAIT_STEP SHALL be absent, and behaviour SHALL be exactly REQ-003 to REQ-014.

Verification
REQ-018 Reset low 2 cycles, then released, num_of_ope=1 -> phase sequence 01,02,04,…,80 on consecutive clocks; instr_done on the 8th; instr_count=1.
REQ-019 num_of_ope=2 -> phases 01…80 with cycle_sel=0, then 10,20,40,80 with cycle_sel=1; one instr_done after 12 cycles; count=1.
REQ-020 stall=1 for 3 cycles at phase 8'h20 -> phase held at 20 for 3 extra cycles, then 40; instruction completes in 11 cycles.
REQ-021 halt=1 throughout the 2nd instruction -> after 16 cycles phase=00, busy=0, instr_count=2, and phase stays 00 for 10 more cycles.
REQ-022 Preload instr_count to 16'hFFFF by running 65535 instructions, then retire one more -> instr_count=16'h0000.
REQ-023 Reset asserted at phase 8'h10, cycle_sel=1 -> outputs zero in the same timestep, with no instr_done pulse.
